batt_mon: RTL
=============

// Module: batt_mon
// PURPOSE
//  Battery monitor between A2D_Intf (batt[11:0]) and piezo_drv / Auth_blk. Replaces the raw compare batt<BATT_THRES.
//  Block-averages batt readings and applies hysteresis and consecutive-reading debounce.
//  Drives a registered batt_low warning to piezo_drv and a sticky batt_crit flag for power-down gating.
// PARAMETERS
//  AVG_SHIFT   3        window = 2**AVG_SHIFT samples per average (legal 1..4)
//  LOW_THRES   12'h800  average strictly below this counts toward LOW
//  OK_THRES    12'h880  average >= this counts toward recovery from LOW (must be > LOW_THRES)
//  CRIT_THRES  12'h700  average strictly below this counts toward CRIT (must be < LOW_THRES)
//  CONSEC      4        consecutive qualifying averages required for a debounced transition (legal 1..15)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset (from rst_synch)
//  smpl       in   1   one-cycle strobe: batt holds a fresh reading (tied to A2D round-robin update)
//  batt       in   12  unsigned battery reading from A2D_Intf
//  batt_avg   out  12  most recent completed window average
//  avg_vld    out  1   one-cycle pulse: batt_avg updated
//  batt_low   out  1   state is LOW or CRIT
//  batt_crit  out  1   state is CRIT (sticky until reset)
// BEHAVIOUR
//  Reset values:
//   - all outputs 0
//   - accumulator 0, sample count 0, debounce count 0, state INIT
//  Averaging:
//   - acc width is 12+AVG_SHIFT, so it cannot overflow.
//   - On each smpl, acc+=batt and smp_cnt++.
//   - On the smpl that completes a window (smp_cnt == 2**AVG_SHIFT-1):
//     - sum = acc+batt
//     - batt_avg <= sum>>AVG_SHIFT (truncate)
//     - acc <= 0, smp_cnt <= 0
//     - avg_vld <= 1 for exactly one cycle
//   - Latency: batt_avg, avg_vld and state all update on the clock edge ending the completing smpl cycle.
//   - smpl held high every cycle is legal: one sample per cycle.
//  FSM (evaluated only when a window completes, using the new average avg):
//   - INIT:
//     - avg < CRIT_THRES -> CRIT
//     - else avg < LOW_THRES -> LOW
//     - else -> OK
//     - The first average transitions immediately with no debounce.
//   - OK:
//     - avg < LOW_THRES: dbnc++; when dbnc reaches CONSEC -> LOW
//     - otherwise dbnc <= 0
//   - LOW:
//     - avg < CRIT_THRES: dbnc++; at CONSEC -> CRIT
//     - avg >= OK_THRES: dbnc++; at CONSEC -> OK
//     - band [CRIT_THRES, OK_THRES): dbnc <= 0, stay
//     - A change of condition class (crit-going vs ok-going) restarts dbnc at 1.
//   - CRIT: terminal; only rst_n exits.
//   - Every state change clears dbnc.
//   - OK never jumps directly to CRIT; a collapse passes through LOW and needs CONSEC further averages.
//  Output registers:
//   - batt_low/batt_crit are registered decodes of the next state.
//   - Both are 0 in INIT.
//  Boundaries:
//   - avg == LOW_THRES is not low.
//   - avg == OK_THRES qualifies for recovery.
//   - avg == CRIT_THRES is not critical.
//   - smpl is ignored except in window accounting; no effect between windows.
//   - rst_n asserted mid-window discards the partial accumulator; outputs go to 0 asynchronously.
// STRUCTURE
//  - segway_pkg: typedef enum logic [1:0] {INIT,OK,LOW,CRIT} batt_state_t; default threshold localparams shared with Segway top.
//  - Sub-module batt_avg (accumulator, sample counter, batt_avg/avg_vld regs).
//  - batt_mon holds the FSM, the debounce counter and the output decode.
// TESTING
//  1. Reset, then 8 smpl with batt=12'h900:
//     - avg_vld pulses once, batt_avg=12'h900
//     - state OK, batt_low=0
//  2. From OK, 4 windows at 12'h7FF:
//     - batt_low rises on the 4th avg_vld, not earlier
//     - repeat with 12'h800: batt_low stays 0
//  3. From LOW, windows 12'h880, 12'h880, 12'h850, then 4x 12'h880:
//     - dbnc resets at 12'h850
//     - batt_low falls only on the final (7th) window
//  4. From LOW, 4 windows at 12'h6FF:
//     - batt_crit=1, batt_low=1
//     - then 10 windows at 12'hFFF: both stay 1 until rst_n
//  5. Window samples {0,0,0,0,FFF,FFF,FFF,FFF} -> batt_avg=12'h7FF (truncation)
//  6. Reset mid-window:
//     - 5 smpl, rst_n pulse, then 8 smpl at 12'h900
//     - first avg_vld shows 12'h900
//     - outputs 0 during reset

Source files
------------

// File: rtl/segway_pkg.sv
// Shared Segway types and default battery thresholds used by batt_mon and the Segway top.
package segway_pkg;

    typedef enum logic [1:0] {INIT, OK, LOW, CRIT} batt_state_t;

    localparam int          BATT_AVG_SHIFT  = 3;
    localparam logic [11:0] BATT_LOW_THRES  = 12'h800;
    localparam logic [11:0] BATT_OK_THRES   = 12'h880;
    localparam logic [11:0] BATT_CRIT_THRES = 12'h700;
    localparam int          BATT_CONSEC     = 4;

endpackage

// File: rtl/batt_avg.sv
// Block averager: sums 2**AVG_SHIFT readings, then publishes the truncated mean with a one-cycle valid.
module batt_avg #(
    parameter int AVG_SHIFT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        smpl,
    input  logic [11:0] batt,
    output logic [11:0] avg_now,
    output logic        win_done,
    output logic [11:0] batt_avg,
    output logic        avg_vld
);

    localparam int ACC_W = 12 + AVG_SHIFT;
    localparam logic [AVG_SHIFT-1:0] CNT_LAST = '1;
    localparam logic [AVG_SHIFT-1:0] CNT_ONE  = AVG_SHIFT'(1);

    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     sum;
    logic [AVG_SHIFT-1:0] smp_cnt;

    // The average is exposed combinationally so the FSM can act on the same edge it is registered.
    assign sum      = acc + ACC_W'(batt);
    assign avg_now  = sum[ACC_W-1:AVG_SHIFT];
    assign win_done = smpl && (smp_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            smp_cnt  <= '0;
            batt_avg <= '0;
            avg_vld  <= 1'b0;
        end else begin
            avg_vld <= win_done;
            if (win_done) begin
                acc      <= '0;
                smp_cnt  <= '0;
                batt_avg <= avg_now;
            end else if (smpl) begin
                acc     <= sum;
                smp_cnt <= smp_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/batt_mon.sv
// Battery monitor: averaged readings drive a debounced OK/LOW/CRIT state with hysteresis.
module batt_mon
    import segway_pkg::*;
#(
    parameter int          AVG_SHIFT  = BATT_AVG_SHIFT,
    parameter logic [11:0] LOW_THRES  = BATT_LOW_THRES,
    parameter logic [11:0] OK_THRES   = BATT_OK_THRES,
    parameter logic [11:0] CRIT_THRES = BATT_CRIT_THRES,
    parameter int          CONSEC     = BATT_CONSEC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        smpl,
    input  logic [11:0] batt,
    output logic [11:0] batt_avg,
    output logic        avg_vld,
    output logic        batt_low,
    output logic        batt_crit
);

    localparam logic [3:0] CONSEC_C = 4'(CONSEC);

    logic [11:0] avg_now;
    logic        win_done;

    batt_state_t state, state_nxt;
    logic [3:0]  dbnc, dbnc_nxt, dbnc_inc, run;
    logic        crit_dir, crit_dir_nxt;
    logic        is_crit, is_low, is_ok;

    batt_avg #(.AVG_SHIFT(AVG_SHIFT)) u_avg (
        .clk      (clk),
        .rst_n    (rst_n),
        .smpl     (smpl),
        .batt     (batt),
        .avg_now  (avg_now),
        .win_done (win_done),
        .batt_avg (batt_avg),
        .avg_vld  (avg_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            dbnc      <= '0;
            crit_dir  <= 1'b0;
            batt_low  <= 1'b0;
            batt_crit <= 1'b0;
        end else begin
            state     <= state_nxt;
            dbnc      <= dbnc_nxt;
            crit_dir  <= crit_dir_nxt;
            batt_low  <= (state_nxt == LOW) || (state_nxt == CRIT);
            batt_crit <= (state_nxt == CRIT);
        end
    end

    // In LOW, crit_dir remembers which direction the running count belongs to so a flip restarts it.
    always_comb begin
        state_nxt    = state;
        dbnc_nxt     = dbnc;
        crit_dir_nxt = crit_dir;
        is_crit      = avg_now < CRIT_THRES;
        is_low       = avg_now < LOW_THRES;
        is_ok        = avg_now >= OK_THRES;
        dbnc_inc     = dbnc + 4'd1;
        run          = 4'd1;
        if (win_done) begin
            case (state)
                INIT: begin
                    dbnc_nxt = '0;
                    if (is_crit)     state_nxt = CRIT;
                    else if (is_low) state_nxt = LOW;
                    else             state_nxt = OK;
                end
                OK: begin
                    if (!is_low) begin
                        dbnc_nxt = '0;
                    end else if (dbnc_inc == CONSEC_C) begin
                        state_nxt = LOW;
                        dbnc_nxt  = '0;
                    end else begin
                        dbnc_nxt = dbnc_inc;
                    end
                end
                LOW: begin
                    if (is_crit || is_ok) begin
                        if ((dbnc != 4'd0) && (crit_dir == is_crit)) run = dbnc_inc;
                        if (run == CONSEC_C) begin
                            state_nxt = is_crit ? CRIT : OK;
                            dbnc_nxt  = '0;
                        end else begin
                            dbnc_nxt     = run;
                            crit_dir_nxt = is_crit;
                        end
                    end else begin
                        dbnc_nxt = '0;
                    end
                end
                CRIT: begin
                    state_nxt = CRIT;
                end
                default: begin
                    state_nxt = INIT;
                    dbnc_nxt  = '0;
                end
            endcase
        end
    end

endmodule
